// File: rtl/perip_fade_pkg.sv
// Shared definitions for the LED fade engine: default data width and
// the per-channel ramp state encoding.
package perip_fade_pkg;

  // Default width of duty, step and divider values.
  localparam int FADE_DW_DEFAULT = 32;

  // Per-channel ramp direction, derived every cycle from Out vs Tgt.
  typedef enum logic [1:0] {
    FADE_HOLD = 2'd0,  // Out == Tgt
    FADE_UP   = 2'd1,  // Out <  Tgt
    FADE_DOWN = 2'd2   // Out >  Tgt
  } fade_state_e;

  // Classify a channel from its current output and its target.
  function automatic fade_state_e fade_classify(input logic lt, input logic gt);
    fade_state_e st;
    st = FADE_HOLD;
    if (lt) begin
      st = FADE_UP;
    end else if (gt) begin
      st = FADE_DOWN;
    end
    return st;
  endfunction

endpackage : perip_fade_pkg

// File: rtl/perip_fade_ch.sv
// One fade channel: a registered duty output that walks toward its
// target by a shared step on each shared tick, clamping at the target
// so it never overshoots and never wraps.
module perip_fade_ch
  import perip_fade_pkg::*;
#(
  parameter int DW = FADE_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fade_en,
  input  logic          tick,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] tgt,
  output logic [DW-1:0] out
);

  logic [DW-1:0] out_q;
  logic [DW-1:0] out_d;
  logic [DW-1:0] step_eff;
  logic [DW-1:0] up_gap;
  logic [DW-1:0] down_gap;
  fade_state_e   state;

  // Ramp direction follows the registered output and the live target.
  always_comb begin
    state = fade_classify(out_q < tgt, out_q > tgt);
  end

  // A zero step would stall the ramp forever, so it behaves as one.
  // The gaps are only consumed in the direction where they cannot underflow.
  always_comb begin
    step_eff = (step == '0) ? DW'(1) : step;
    up_gap   = tgt - out_q;
    down_gap = out_q - tgt;
  end

  // Next output: bypass copies the target, otherwise move one clamped step per tick.
  always_comb begin
    out_d = out_q;
    if (!fade_en) begin
      out_d = tgt;
    end else if (tick) begin
      unique case (state)
        FADE_UP: begin
          // Landing exactly on the target when the gap fits in one step
          // also guarantees out_q + step_eff never exceeds 2^DW-1.
          out_d = (up_gap <= step_eff) ? tgt : (out_q + step_eff);
        end
        FADE_DOWN: begin
          // Same clamp downward keeps out_q - step_eff above zero.
          out_d = (down_gap <= step_eff) ? tgt : (out_q - step_eff);
        end
        default: begin
          out_d = out_q;
        end
      endcase
    end
  end

  // Output register; reset discards any ramp progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : perip_fade_ch

// File: rtl/perip_led_fade.sv
// RGB LED duty fader: a shared step divider drives three identical fade
// channels that ramp the PWM duties toward the register-bank targets.
// With fading disabled the targets pass straight through a register.
module perip_led_fade
  import perip_fade_pkg::*;
#(
  parameter int DW = FADE_DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          FADE_EN,
  input  logic [DW-1:0] FADE_DIV,
  input  logic [DW-1:0] FADE_STEP,
  input  logic [DW-1:0] LEDR_Puty_Tgt,
  input  logic [DW-1:0] LEDG_Puty_Tgt,
  input  logic [DW-1:0] LEDB_Puty_Tgt,
  output logic [DW-1:0] LEDR_Puty_Out,
  output logic [DW-1:0] LEDG_Puty_Out,
  output logic [DW-1:0] LEDB_Puty_Out,
  output logic          FADE_BUSY
);

  localparam int NCH = 3;

  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          tick;
  logic [DW-1:0] tgt_arr [NCH];
  logic [DW-1:0] out_arr [NCH];
  logic [NCH-1:0] ch_busy;

  // Step divider: the >= compare means a divider lowered below the running
  // count fires on the very next cycle instead of waiting for a wrap.
  always_comb begin
    tick   = 1'b0;
    dcnt_d = '0;
    if (FADE_EN) begin
      if (dcnt_q >= FADE_DIV) begin
        tick   = 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Divider counter register; parked at zero in bypass so re-enabling
  // always gives a full FADE_DIV+1 period before the first step.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  // Gather the per-colour targets so the channels can be generated uniformly.
  always_comb begin
    tgt_arr[0] = LEDR_Puty_Tgt;
    tgt_arr[1] = LEDG_Puty_Tgt;
    tgt_arr[2] = LEDB_Puty_Tgt;
  end

  // Three identical channels sharing the tick and step so they move together.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      perip_fade_ch #(
        .DW (DW)
      ) u_ch (
        .clk     (CLK),
        .rst_n   (RST_n),
        .fade_en (FADE_EN),
        .tick    (tick),
        .step    (FADE_STEP),
        .tgt     (tgt_arr[gi]),
        .out     (out_arr[gi])
      );

      // A channel is busy while its registered duty has not reached the live target.
      always_comb begin
        ch_busy[gi] = (out_arr[gi] != tgt_arr[gi]);
      end
    end
  endgenerate

  // Busy is deliberately combinational so software sees a target write immediately.
  always_comb begin
    FADE_BUSY = |ch_busy;
  end

  assign LEDR_Puty_Out = out_arr[0];
  assign LEDG_Puty_Out = out_arr[1];
  assign LEDB_Puty_Out = out_arr[2];

endmodule : perip_led_fade

// File: tb/tb_perip_led_fade.sv
// Directed self-checking bench for perip_led_fade: ramp timing, saturation
// at the extremes, direction reversal, bypass, async reset and divider change.
`timescale 1ns/1ps
module tb_perip_led_fade;

  localparam int DW = 32;

  logic          CLK;
  logic          RST_n;
  logic          FADE_EN;
  logic [DW-1:0] FADE_DIV;
  logic [DW-1:0] FADE_STEP;
  logic [DW-1:0] LEDR_Puty_Tgt;
  logic [DW-1:0] LEDG_Puty_Tgt;
  logic [DW-1:0] LEDB_Puty_Tgt;
  logic [DW-1:0] LEDR_Puty_Out;
  logic [DW-1:0] LEDG_Puty_Out;
  logic [DW-1:0] LEDB_Puty_Out;
  logic          FADE_BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  perip_led_fade #(.DW(DW)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .FADE_EN       (FADE_EN),
    .FADE_DIV      (FADE_DIV),
    .FADE_STEP     (FADE_STEP),
    .LEDR_Puty_Tgt (LEDR_Puty_Tgt),
    .LEDG_Puty_Tgt (LEDG_Puty_Tgt),
    .LEDB_Puty_Tgt (LEDB_Puty_Tgt),
    .LEDR_Puty_Out (LEDR_Puty_Out),
    .LEDG_Puty_Out (LEDG_Puty_Out),
    .LEDB_Puty_Out (LEDB_Puty_Out),
    .FADE_BUSY     (FADE_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare one observed value with its hand-computed expectation.
  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_n         = 1'b0;
    FADE_EN       = 1'b0;
    FADE_DIV      = 32'd3;
    FADE_STEP     = 32'd10;
    LEDR_Puty_Tgt = '0;
    LEDG_Puty_Tgt = '0;
    LEDB_Puty_Tgt = '0;

    // Reset state
    #12;
    check_eq("rst_r", LEDR_Puty_Out, 32'd0);
    check_eq("rst_g", LEDG_Puty_Out, 32'd0);
    check_eq("rst_b", LEDB_Puty_Out, 32'd0);
    check_eq("rst_busy", {31'd0, FADE_BUSY}, 32'd0);
    #11 RST_n = 1'b1;
    step_clk(1);

    // DIV=3 STEP=10 R 0->25: steps land on edges 4, 8, 12
    FADE_EN = 1'b1;
    LEDR_Puty_Tgt = 32'd25;
    #1;
    check_eq("r27_busy_start", {31'd0, FADE_BUSY}, 32'd1);
    step_clk(3);  check_eq("r27_e3", LEDR_Puty_Out, 32'd0);
    step_clk(1);  check_eq("r27_e4", LEDR_Puty_Out, 32'd10);
    step_clk(3);  check_eq("r27_e7", LEDR_Puty_Out, 32'd10);
    step_clk(1);  check_eq("r27_e8", LEDR_Puty_Out, 32'd20);
    step_clk(3);  check_eq("r27_e11_busy", {31'd0, FADE_BUSY}, 32'd1);
    step_clk(1);  check_eq("r27_e12", LEDR_Puty_Out, 32'd25);
    check_eq("r27_e12_busy", {31'd0, FADE_BUSY}, 32'd0);

    // Saturation at the top and bottom of the range on G
    FADE_EN = 1'b0;
    LEDG_Puty_Tgt = 32'hFFFF_FFF0;
    step_clk(1);  check_eq("r28_preload", LEDG_Puty_Out, 32'hFFFF_FFF0);
    FADE_DIV  = 32'd0;
    FADE_STEP = 32'hFFFF_FFF0;
    LEDG_Puty_Tgt = 32'hFFFF_FFFF;
    FADE_EN = 1'b1;
    step_clk(1);  check_eq("r28_top", LEDG_Puty_Out, 32'hFFFF_FFFF);
    LEDG_Puty_Tgt = 32'd0;
    step_clk(1);  check_eq("r28_down1", LEDG_Puty_Out, 32'h0000_000F);
    step_clk(1);  check_eq("r28_down2", LEDG_Puty_Out, 32'd0);

    // B ramp 0->100 by 5, reversed to 20 at Out=40
    FADE_STEP = 32'd5;
    LEDB_Puty_Tgt = 32'd100;
    step_clk(8);  check_eq("r29_at40", LEDB_Puty_Out, 32'd40);
    LEDB_Puty_Tgt = 32'd20;
    step_clk(1);  check_eq("r29_35", LEDB_Puty_Out, 32'd35);
    step_clk(1);  check_eq("r29_30", LEDB_Puty_Out, 32'd30);
    step_clk(1);  check_eq("r29_25", LEDB_Puty_Out, 32'd25);
    step_clk(1);  check_eq("r29_20", LEDB_Puty_Out, 32'd20);
    step_clk(1);  check_eq("r29_hold", LEDB_Puty_Out, 32'd20);
    check_eq("r29_busy", {31'd0, FADE_BUSY}, 32'd0);

    // Bypass: targets appear one cycle later
    FADE_EN = 1'b0;
    LEDR_Puty_Tgt = 32'd7;
    LEDG_Puty_Tgt = 32'd8;
    LEDB_Puty_Tgt = 32'd9;
    #1;
    check_eq("r30_busy_pre", {31'd0, FADE_BUSY}, 32'd1);
    step_clk(1);
    check_eq("r30_r", LEDR_Puty_Out, 32'd7);
    check_eq("r30_g", LEDG_Puty_Out, 32'd8);
    check_eq("r30_b", LEDB_Puty_Out, 32'd9);
    check_eq("r30_busy", {31'd0, FADE_BUSY}, 32'd0);
    // Disable mid-ramp snaps to target
    FADE_EN = 1'b1;
    FADE_DIV = 32'd3;
    FADE_STEP = 32'd1;
    LEDR_Puty_Tgt = 32'd100;
    step_clk(4);  check_eq("r30_ramp", LEDR_Puty_Out, 32'd8);
    step_clk(2);
    FADE_EN = 1'b0;
    step_clk(1);  check_eq("r30_snap", LEDR_Puty_Out, 32'd100);
    check_eq("r30_snap_busy", {31'd0, FADE_BUSY}, 32'd0);

    // Async reset mid-ramp at Out=50
    LEDR_Puty_Tgt = 32'd0;
    step_clk(1);  check_eq("r31_zero", LEDR_Puty_Out, 32'd0);
    FADE_DIV = 32'd0;
    FADE_STEP = 32'd10;
    LEDR_Puty_Tgt = 32'd200;
    FADE_EN = 1'b1;
    step_clk(5);  check_eq("r31_at50", LEDR_Puty_Out, 32'd50);
    #2 RST_n = 1'b0;
    #1;
    check_eq("r31_async_r", LEDR_Puty_Out, 32'd0);
    check_eq("r31_async_g", LEDG_Puty_Out, 32'd0);
    check_eq("r31_async_b", LEDB_Puty_Out, 32'd0);
    step_clk(2);  check_eq("r31_held_r", LEDR_Puty_Out, 32'd0);
    FADE_DIV = 32'd3;
    #2 RST_n = 1'b1;
    step_clk(3);  check_eq("r31_rel_e3", LEDR_Puty_Out, 32'd0);
    step_clk(1);  check_eq("r31_rel_e4", LEDR_Puty_Out, 32'd10);

    // Divider lowered below the running count; STEP=0 acts as 1
    FADE_EN = 1'b0;
    LEDR_Puty_Tgt = 32'd0;
    step_clk(1);  check_eq("r32_zero", LEDR_Puty_Out, 32'd0);
    FADE_DIV = 32'd100;
    FADE_STEP = 32'd0;
    LEDR_Puty_Tgt = 32'd1000;
    FADE_EN = 1'b1;
    step_clk(60); check_eq("r32_cnt60", LEDR_Puty_Out, 32'd0);
    FADE_DIV = 32'd10;
    step_clk(1);  check_eq("r32_next", LEDR_Puty_Out, 32'd1);
    step_clk(10); check_eq("r32_wait10", LEDR_Puty_Out, 32'd1);
    step_clk(1);  check_eq("r32_per11", LEDR_Puty_Out, 32'd2);
    check_eq("r32_busy", {31'd0, FADE_BUSY}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_perip_led_fade

// File: doc/perip_led_fade.md
PERIP_LED_FADE -- requirements
Module: perip_led_fade

Interface
REQ-001 Parameter DW, default 32: width of all duty, step and divider values.
REQ-002 CLK  input  1  system clock (sysclk domain), all logic on its rising edge.
REQ-003 RST_n  input  1  reset, asynchronous assert, active-low.
REQ-004 FADE_EN  input  1  1 = ramp toward targets, 0 = bypass.
REQ-005 FADE_DIV  input  DW  CLK cycles per step minus one.
REQ-006 FADE_STEP  input  DW  duty increment per step; 0 treated as 1.
REQ-007 LEDR_Puty_Tgt / LEDG_Puty_Tgt / LEDB_Puty_Tgt  input  DW each  target duties from the flexbus register bank.
REQ-008 LEDR_Puty_Out / LEDG_Puty_Out / LEDB_Puty_Out  output  DW each  current duties, feed perip_BZLED LEDx_Puty_Set.
REQ-009 FADE_BUSY  output  1  high while any channel output differs from its target.

Function
REQ-010 The block SHALL hold a divider counter DCNT (DW bits) and issue a one-cycle TICK when FADE_EN=1 and DCNT>=FADE_DIV, clearing DCNT on the same edge, else incrementing DCNT.
REQ-011 FADE_DIV=0 SHALL produce TICK every cycle; a step period SHALL be FADE_DIV+1 cycles.
REQ-012 A FADE_DIV decrease below the running DCNT SHALL cause TICK on the next cycle (>= compare), with no wrap-around wait.
REQ-013 Each channel SHALL run a 3-state FSM: HOLD (Out==Tgt), UP (Out<Tgt), DOWN (Out>Tgt), evaluated every cycle from registered Out and the live Tgt.
REQ-014 On TICK in UP: Out <= (Tgt-Out <= STEP) ? Tgt : Out+STEP; in DOWN: Out <= (Out-Tgt <= STEP) ? Tgt : Out-STEP; in HOLD: no change.
REQ-015 Arithmetic SHALL be unsigned DW-bit with no overflow or underflow: Out never passes Tgt, never wraps past 0 or 2^DW-1.
REQ-016 A target change mid-ramp SHALL take effect at the next TICK, ramping from the current Out; a direction reversal is legal.
REQ-017 FADE_EN=0 SHALL load Out <= Tgt on every edge (latency 1 cycle) and hold DCNT at 0.
REQ-018 FADE_EN 1->0 mid-ramp SHALL snap Out to Tgt next cycle; 0->1 SHALL start counting from DCNT=0, first TICK after FADE_DIV+1 cycles.
REQ-019 All three channels SHALL share TICK and STEP and move on the same edge.
REQ-020 FADE_BUSY SHALL be combinational: OR over channels of (Out != Tgt); 0 in bypass one cycle after a target change.
REQ-021 Outputs SHALL be registered; no combinational path from Tgt to Out.

Reset
REQ-022 RST_n low SHALL immediately clear DCNT and all Out to 0 and force every FSM to its state derived from Out=0.
REQ-023 Reset mid-ramp SHALL discard progress; after release with FADE_EN=1 channels ramp from 0 toward Tgt.
REQ-024 No output SHALL toggle while RST_n is low other than the initial clear.

Structure
REQ-025 Shared package perip_fade_pkg SHALL hold DW default and the FSM state encoding (HOLD/UP/DOWN).
REQ-026 One sub-module perip_fade_ch (one Out register, FSM, saturating step logic) SHALL be instantiated three times; divider and FADE_BUSY reside in the top.

Verification
REQ-027 EN=1, DIV=3, STEP=10, R target 0->25: Out=10 at first TICK (cycle 4), 20 at cycle 8, 25 at cycle 12; BUSY falls at cycle 12.
REQ-028 EN=1, DIV=0, STEP=0xFFFFFFF0, G Out=0xFFFFFFF0 target 0xFFFFFFFF: Out=0xFFFFFFFF in one TICK, no wrap; then target 0: Out=0 in two TICKs (0x0000000F, then 0).
REQ-029 Ramp B 0->100 STEP=5 DIV=0, at Out=40 set target 20: Out 35, 30, 25, 20 then HOLD.
REQ-030 EN=0, targets R/G/B=7/8/9: Outs equal 7/8/9 one cycle later, BUSY=0; toggle EN 1->0 mid-ramp: snap to target next cycle.
REQ-031 RST_n pulsed low at Out=50 mid-ramp, asynchronous to CLK: Out=0 immediately, DCNT=0, ramp restarts to target after release.
REQ-032 DIV=100 with DCNT=60, DIV changed to 10: TICK on next cycle, then every 11 cycles.
